// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath blocks.
//   state_t : accumulator controller state encoding (IDLE=0, ACCUM=1, DONE=2)
//   FP_ZERO : IEEE-754 single-precision positive zero
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_accum_ctrl_adder.sv
// ADDER: combinational IEEE-754 single-precision adder/subtractor,
// round-to-nearest-even.
//   OP_A, OP_B  : operands
//   OP          : 0 = A + B, 1 = A - B
//   IEEE_FORMAT : result
module ADDER (
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic        OP,
  output logic [31:0] IEEE_FORMAT
);

  logic        sa, sb, sl, ss, swap, sticky, rbit;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [7:0]  ea, eb;
  logic [9:0]  el, es, diff, ex, sh;
  logic [23:0] ml, ms;
  logic [26:0] mlx, msx, msfull;
  logic [27:0] sum;
  logic [24:0] rnd;
  logic [4:0]  lz;

  always_comb begin
    sa    = OP_A[31];
    sb    = OP_B[31] ^ OP;
    ea    = OP_A[30:23];
    eb    = OP_B[30:23];
    nan_a = (ea == 8'hFF) && (OP_A[22:0] != '0);
    nan_b = (eb == 8'hFF) && (OP_B[22:0] != '0);
    inf_a = (ea == 8'hFF) && (OP_A[22:0] == '0);
    inf_b = (eb == 8'hFF) && (OP_B[22:0] == '0);

    // Order operands by magnitude so the mantissa difference is never negative.
    swap = OP_B[30:0] > OP_A[30:0];
    sl   = swap ? sb : sa;
    ss   = swap ? sa : sb;
    el   = {2'b00, swap ? eb : ea};
    es   = {2'b00, swap ? ea : eb};
    ml   = swap ? {eb != '0, OP_B[22:0]} : {ea != '0, OP_A[22:0]};
    ms   = swap ? {ea != '0, OP_A[22:0]} : {eb != '0, OP_B[22:0]};
    if (el == '0) el = 10'd1;
    if (es == '0) es = 10'd1;
    diff = el - es;

    // Three extra bits below the mantissa: guard, round, sticky.
    mlx    = {ml, 3'b000};
    msfull = {ms, 3'b000};
    msx    = '0;
    sticky = 1'b0;
    if (diff >= 10'd27) begin
      sticky = |ms;
    end else begin
      msx = msfull >> diff;
      for (int unsigned i = 0; i < 27; i++) begin
        if (10'(i) < diff) sticky = sticky | msfull[i];
      end
    end
    msx[0] = msx[0] | sticky;

    if (sl == ss) sum = {1'b0, mlx} + {1'b0, msx};
    else          sum = {1'b0, mlx} - {1'b0, msx};

    ex = el;
    lz = '0;
    sh = '0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      ex  = el + 10'd1;
    end else begin
      for (int unsigned i = 0; i < 27; i++) begin
        if (sum[i]) lz = 5'(26 - i);
      end
      // Left shift stops at the minimum exponent, leaving a subnormal.
      sh  = ({5'b0, lz} >= ex) ? ex - 10'd1 : {5'b0, lz};
      sum = sum << sh;
      ex  = ex - sh;
    end

    rbit = sum[2] & (sum[1] | sum[0] | sum[3]);
    rnd  = {1'b0, sum[26:3]} + {24'b0, rbit};
    if (rnd[24]) begin
      rnd = {1'b0, rnd[24:1]};
      ex  = ex + 10'd1;
    end

    if (ex >= 10'd255) IEEE_FORMAT = {sl, 8'hFF, 23'b0};
    else               IEEE_FORMAT = {sl, rnd[23] ? ex[7:0] : 8'h00, rnd[22:0]};

    // Exact cancellation gives +0; only -0 + -0 keeps the negative sign.
    if (sum == '0) IEEE_FORMAT = {sl & ss, 31'b0};

    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) IEEE_FORMAT = 32'h7FC0_0000;
    else if (inf_a) IEEE_FORMAT = {sa, 8'hFF, 23'b0};
    else if (inf_b) IEEE_FORMAT = {sb, 8'hFF, 23'b0};
  end

endmodule

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: accumulates N_TERMS FP32 products into one sum using a
// single combinational ADDER (running sum on A, new term on B).
//   CLK, RST_N          : clock, async active-low reset
//   CLEAR               : synchronous abort to IDLE, drops partial/pending sum
//   IN_DATA/IN_VALID/IN_READY    : upstream term handshake
//   OUT_DATA/OUT_VALID/OUT_READY : downstream result handshake
//   BUSY                : state is not IDLE
//   TERM_CNT            : terms absorbed into the current window
module fp_accum_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned N_TERMS = 9,
  parameter int unsigned CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLEAR,
  input  logic [31:0]      IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [31:0]      OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic [CNT_W-1:0] TERM_CNT
);

  state_t             state_q, state_d;
  logic [31:0]        acc_q, acc_d, add_sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               in_fire, out_fire;

  ADDER u_adder (
    .OP_A        (acc_q),
    .OP_B        (IN_DATA),
    .OP          (1'b0),
    .IEEE_FORMAT (add_sum)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= FP_ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    IN_READY  = !CLEAR && ((state_q != ST_DONE) || OUT_READY);
    OUT_VALID = (state_q == ST_DONE);
    OUT_DATA  = acc_q;
    BUSY      = (state_q != ST_IDLE);
    TERM_CNT  = cnt_q;
    in_fire   = IN_VALID && IN_READY;
    out_fire  = OUT_VALID && OUT_READY;
    cnt_inc   = cnt_q + CNT_W'(1);

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    if (CLEAR) begin
      state_d = ST_IDLE;
      acc_d   = FP_ZERO;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            state_d = ST_ACCUM;
            acc_d   = IN_DATA;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (in_fire) begin
            acc_d = add_sum;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(N_TERMS)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // A term can only be accepted here when OUT_READY is high, so
          // in_fire implies the result is consumed on the same edge.
          if (out_fire) begin
            if (in_fire) begin
              state_d = ST_ACCUM;
              acc_d   = IN_DATA;
              cnt_d   = CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = FP_ZERO;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
module tb_fp_accum_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N, CLEAR, IN_VALID, OUT_READY;
  logic [31:0] IN_DATA;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_out_data;
  logic [1:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_data;
  logic [1:0]  b_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 CLK = ~CLK;

  fp_accum_ctrl #(.N_TERMS(2)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(a_in_ready),
    .OUT_DATA(a_out_data), .OUT_VALID(a_out_valid), .OUT_READY(OUT_READY),
    .BUSY(a_busy), .TERM_CNT(a_cnt)
  );

  fp_accum_ctrl #(.N_TERMS(3)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .CLEAR(CLEAR),
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(b_in_ready),
    .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid), .OUT_READY(OUT_READY),
    .BUSY(b_busy), .TERM_CNT(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; IN_DATA = '0;
    #2;
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_data",  a_out_data, 32'h0);
    chk("rst_a_busy",  32'(a_busy), 0);
    chk("rst_a_cnt",   32'(a_cnt), 0);
    chk("rst_a_ready", 32'(a_in_ready), 1);
    chk("rst_b_busy",  32'(b_busy), 0);
    tick(); tick();
    RST_N = 1'b1;

    // Two-term window
    IN_VALID = 1'b1; IN_DATA = 32'h3F00_0000; #1;
    chk("w2_ready_idle", 32'(a_in_ready), 1);
    tick();
    chk("w2_cnt1",   32'(a_cnt), 1);
    chk("w2_busy1",  32'(a_busy), 1);
    chk("w2_valid1", 32'(a_out_valid), 0);
    IN_DATA = 32'h3EE0_0000;
    tick();
    IN_VALID = 1'b0; #1;
    chk("w2_valid", 32'(a_out_valid), 1);
    chk("w2_data",  a_out_data, 32'h3F70_0000);
    chk("w2_cnt2",  32'(a_cnt), 2);
    chk("w2_ready_bp", 32'(a_in_ready), 0);
    OUT_READY = 1'b1; #1;
    chk("w2_ready_pass", 32'(a_in_ready), 1);
    tick();
    chk("w2_consumed_valid", 32'(a_out_valid), 0);
    chk("w2_consumed_busy",  32'(a_busy), 0);
    chk("w2_consumed_cnt",   32'(a_cnt), 0);

    // Cancellation
    do_reset();
    IN_VALID = 1'b1; IN_DATA = 32'h3EE0_0000; tick();
    IN_DATA = 32'hBEE0_0000; tick();
    IN_VALID = 1'b0;
    chk("cancel_valid", 32'(a_out_valid), 1);
    chk("cancel_data",  a_out_data, 32'h0000_0000);

    // Stall and backpressure, N_TERMS=3
    do_reset();
    IN_VALID = 1'b1; IN_DATA = 32'h3F00_0000; tick();
    IN_VALID = 1'b0; tick(); tick();
    chk("stall_cnt",  32'(b_cnt), 1);
    chk("stall_data", b_out_data, 32'h3F00_0000);
    IN_VALID = 1'b1; IN_DATA = 32'h3EE0_0000; tick();
    IN_VALID = 1'b0; tick();
    chk("stall_cnt2",  32'(b_cnt), 2);
    chk("stall_data2", b_out_data, 32'h3F70_0000);
    chk("stall_valid_early", 32'(b_out_valid), 0);
    IN_VALID = 1'b1; IN_DATA = 32'hBEE0_0000; tick();
    IN_DATA = 32'h4000_0000;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(b_out_valid), 1);
      chk("bp_data",  b_out_data, 32'h3F00_0000);
      chk("bp_ready", 32'(b_in_ready), 0);
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1; tick();
    chk("bp_done_idle", 32'(b_busy), 0);

    // Back-to-back windows, N_TERMS=2
    do_reset();
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    IN_DATA = 32'h3F00_0000; tick();
    IN_DATA = 32'h3EE0_0000; tick();
    chk("b2b_first_valid", 32'(a_out_valid), 1);
    chk("b2b_first_data",  a_out_data, 32'h3F70_0000);
    IN_DATA = 32'hBF00_0000; #1;
    chk("b2b_ready_done", 32'(a_in_ready), 1);
    tick();
    chk("b2b_cnt_restart", 32'(a_cnt), 1);
    chk("b2b_busy",        32'(a_busy), 1);
    chk("b2b_valid_gap",   32'(a_out_valid), 0);
    IN_DATA = 32'hBEE0_0000; tick();
    IN_VALID = 1'b0;
    chk("b2b_second_valid", 32'(a_out_valid), 1);
    chk("b2b_second_data",  a_out_data, 32'hBF70_0000);
    tick();
    chk("b2b_idle", 32'(a_busy), 0);

    // CLEAR mid-window and in DONE
    do_reset();
    IN_VALID = 1'b1; IN_DATA = 32'h3F00_0000; tick();
    IN_DATA = 32'h3EE0_0000; CLEAR = 1'b1; #1;
    chk("clr_ready", 32'(a_in_ready), 0);
    tick();
    CLEAR = 1'b0;
    chk("clr_busy", 32'(a_busy), 0);
    chk("clr_cnt",  32'(a_cnt), 0);
    chk("clr_data", a_out_data, 32'h0);
    IN_DATA = 32'h3EE0_0000; tick();
    IN_DATA = 32'h3F00_0000; tick();
    IN_VALID = 1'b0;
    chk("clr_next_valid", 32'(a_out_valid), 1);
    chk("clr_next_data",  a_out_data, 32'h3F70_0000);
    CLEAR = 1'b1; tick();
    CLEAR = 1'b0;
    chk("clr_done_valid", 32'(a_out_valid), 0);
    chk("clr_done_data",  a_out_data, 32'h0);

    // Asynchronous reset mid-window and in DONE
    IN_VALID = 1'b1; IN_DATA = 32'h3F00_0000; tick();
    chk("arst_pre_busy", 32'(a_busy), 1);
    #2 RST_N = 1'b0; IN_VALID = 1'b0; #1;
    chk("arst_mid_busy", 32'(a_busy), 0);
    chk("arst_mid_cnt",  32'(a_cnt), 0);
    chk("arst_mid_data", a_out_data, 32'h0);
    tick();
    RST_N = 1'b1;
    IN_VALID = 1'b1; IN_DATA = 32'h3F00_0000; tick();
    IN_DATA = 32'h3EE0_0000; tick();
    IN_VALID = 1'b0;
    chk("arst_pre_valid", 32'(a_out_valid), 1);
    #2 RST_N = 1'b0; #1;
    chk("arst_done_valid", 32'(a_out_valid), 0);
    chk("arst_done_data",  a_out_data, 32'h0);
    chk("arst_done_busy",  32'(a_busy), 0);
    chk("arst_done_ready", 32'(a_in_ready), 1);
    tick();
    RST_N = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
